mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/asm18_mem_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/rd_tag_pipe.sv | 32 +++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/asm18_mem_pkg.sv
// Shared types and sizes for the ASM18 memory port arbiter.
package asm18_mem_pkg;

  localparam int WORD_SIZE = 18;
  localparam int ADDR_SIZE = 10;

  // Identifies which master owns an access.
  typedef logic master_id_t;

  localparam master_id_t MASTER_0 = 1'b0;
  localparam master_id_t MASTER_1 = 1'b1;

  // One entry of the read-return pipeline.
  typedef struct packed {
    logic       valid;
    master_id_t id;
  } rd_tag_t;

  localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, id: MASTER_0};

  // True when a returning tag belongs to the given master.
  function automatic logic tag_hit(input rd_tag_t tag, input master_id_t id);
    return tag.valid && (tag.id == id);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of both master ports plus the single RAM port around the arbiter.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = asm18_mem_pkg::WORD_SIZE,
  parameter int ADDR_SIZE = asm18_mem_pkg::ADDR_SIZE
);

  logic                 m0_req;
  logic                 m0_we;
  logic [ADDR_SIZE-1:0] m0_addr;
  logic [WORD_SIZE-1:0] m0_wdata;
  logic                 m0_ack;
  logic                 m0_rvalid;
  logic [WORD_SIZE-1:0] m0_rdata;

  logic                 m1_req;
  logic                 m1_we;
  logic [ADDR_SIZE-1:0] m1_addr;
  logic [WORD_SIZE-1:0] m1_wdata;
  logic                 m1_ack;
  logic                 m1_rvalid;
  logic [WORD_SIZE-1:0] m1_rdata;

  logic                 m0_exclusive;

  logic [ADDR_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0] mem_write;
  logic                 mem_wren;
  logic [WORD_SIZE-1:0] mem_read;

  // Everything surrounding the arbiter: the two masters and the RAM.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_exclusive,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_read,
    input  m0_ack, m0_rvalid, m0_rdata,
    input  m1_ack, m1_rvalid, m1_rdata,
    input  mem_address, mem_write, mem_wren
  );

  // The arbiter itself.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_exclusive,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_read,
    output m0_ack, m0_rvalid, m0_rdata,
    output m1_ack, m1_rvalid, m1_rdata,
    output mem_address, mem_write, mem_wren
  );

endinterface

// File: rtl/rd_tag_pipe.sv
// Delay line carrying (valid, master id) for each issued read so the tag
// lines up with the RAM data RD_LATENCY cycles later.
module rd_tag_pipe
  import asm18_mem_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk_50M,
  input  logic    reset_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_r [RD_LATENCY];

  // Shift tags one stage per cycle; reset drops every in-flight read.
  always_ff @(posedge clk_50M) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        stage_r[i] <= RD_TAG_IDLE;
      end
    end else begin
      stage_r[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign tag_out = stage_r[RD_LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-port RAM. The grant,
// ack and RAM command are combinational in the grant cycle; read data is
// steered back to its owner by the tag pipeline.
module mem_port_arbiter #(
  parameter int WORD_SIZE  = asm18_mem_pkg::WORD_SIZE,
  parameter int ADDR_SIZE  = asm18_mem_pkg::ADDR_SIZE,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk_50M,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  import asm18_mem_pkg::*;

  master_id_t           prio_r;
  master_id_t           prio_next_s;
  logic                 grant0_s;
  logic                 grant1_s;
  logic [ADDR_SIZE-1:0] addr_r;
  logic [ADDR_SIZE-1:0] addr_s;
  logic [WORD_SIZE-1:0] wdata_r;
  logic [WORD_SIZE-1:0] wdata_s;
  logic                 wren_s;
  rd_tag_t              tag_in_s;
  rd_tag_t              tag_out_s;
  logic                 rvalid0_s;
  logic                 rvalid1_s;
  logic [WORD_SIZE-1:0] rdata0_r;
  logic [WORD_SIZE-1:0] rdata1_r;

  // Choose at most one winner; a lone requester always wins, and nothing
  // is granted while reset is held.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!reset_n) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (bus.m0_req && (bus.m0_exclusive || !bus.m1_req || prio_r == MASTER_0)) begin
      grant0_s = 1'b1;
    end else if (bus.m1_req) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Build the RAM command, read tag and next priority from the winner;
  // address and write data hold their last values when idle.
  always_comb begin
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    wren_s      = 1'b0;
    tag_in_s    = RD_TAG_IDLE;
    prio_next_s = prio_r;
    if (grant0_s) begin
      addr_s      = bus.m0_addr;
      wdata_s     = bus.m0_wdata;
      wren_s      = bus.m0_we;
      tag_in_s    = '{valid: ~bus.m0_we, id: MASTER_0};
      prio_next_s = bus.m0_exclusive ? prio_r : MASTER_1;
    end else if (grant1_s) begin
      addr_s      = bus.m1_addr;
      wdata_s     = bus.m1_wdata;
      wren_s      = bus.m1_we;
      tag_in_s    = '{valid: ~bus.m1_we, id: MASTER_1};
      prio_next_s = MASTER_0;
    end else begin
      addr_s      = addr_r;
      wdata_s     = wdata_r;
      wren_s      = 1'b0;
      tag_in_s    = RD_TAG_IDLE;
      prio_next_s = prio_r;
    end
  end

  // Round-robin pointer and the held RAM address/data.
  always_ff @(posedge clk_50M) begin
    if (!reset_n) begin
      prio_r  <= MASTER_0;
      addr_r  <= {ADDR_SIZE{1'b0}};
      wdata_r <= {WORD_SIZE{1'b0}};
    end else begin
      prio_r  <= prio_next_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
    end
  end

  rd_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk_50M (clk_50M),
    .reset_n (reset_n),
    .tag_in  (tag_in_s),
    .tag_out (tag_out_s)
  );

  // Gating with reset_n keeps a read caught by reset from ever returning.
  assign rvalid0_s = reset_n && tag_hit(tag_out_s, MASTER_0);
  assign rvalid1_s = reset_n && tag_hit(tag_out_s, MASTER_1);

  // Remember each master's last returned word between rvalid pulses.
  always_ff @(posedge clk_50M) begin
    if (!reset_n) begin
      rdata0_r <= {WORD_SIZE{1'b0}};
      rdata1_r <= {WORD_SIZE{1'b0}};
    end else begin
      if (rvalid0_s) begin
        rdata0_r <= bus.mem_read;
      end
      if (rvalid1_s) begin
        rdata1_r <= bus.mem_read;
      end
    end
  end

  assign bus.m0_ack      = grant0_s;
  assign bus.m1_ack      = grant1_s;
  assign bus.mem_address = addr_s;
  assign bus.mem_write   = wdata_s;
  assign bus.mem_wren    = wren_s;
  assign bus.m0_rvalid   = rvalid0_s;
  assign bus.m1_rvalid   = rvalid1_s;
  assign bus.m0_rdata    = rvalid0_s ? bus.mem_read : rdata0_r;
  assign bus.m1_rdata    = rvalid1_s ? bus.mem_read : rdata1_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter with a 1-cycle RAM and one with a 2-cycle RAM,
// both driven by the same master stimulus.
module tb_mem_port_arbiter;

  logic        clk_50M;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we, m0_exclusive;
  logic [9:0]  m0_addr, m1_addr;
  logic [17:0] m0_wdata, m1_wdata;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt0, cnt1;

  mem_port_arbiter_if #(.WORD_SIZE(18), .ADDR_SIZE(10)) bus1 ();
  mem_port_arbiter_if #(.WORD_SIZE(18), .ADDR_SIZE(10)) bus2 ();

  mem_port_arbiter #(.WORD_SIZE(18), .ADDR_SIZE(10), .RD_LATENCY(1)) u_dut1 (
    .clk_50M (clk_50M),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  mem_port_arbiter #(.WORD_SIZE(18), .ADDR_SIZE(10), .RD_LATENCY(2)) u_dut2 (
    .clk_50M (clk_50M),
    .reset_n (reset_n),
    .bus     (bus2)
  );

  assign bus1.m0_req = m0_req;   assign bus2.m0_req = m0_req;
  assign bus1.m0_we = m0_we;     assign bus2.m0_we = m0_we;
  assign bus1.m0_addr = m0_addr; assign bus2.m0_addr = m0_addr;
  assign bus1.m0_wdata = m0_wdata; assign bus2.m0_wdata = m0_wdata;
  assign bus1.m1_req = m1_req;   assign bus2.m1_req = m1_req;
  assign bus1.m1_we = m1_we;     assign bus2.m1_we = m1_we;
  assign bus1.m1_addr = m1_addr; assign bus2.m1_addr = m1_addr;
  assign bus1.m1_wdata = m1_wdata; assign bus2.m1_wdata = m1_wdata;
  assign bus1.m0_exclusive = m0_exclusive;
  assign bus2.m0_exclusive = m0_exclusive;

  // RAM models: 1-cycle read for bus1, 2-cycle read for bus2.
  logic [17:0] ram1 [0:1023];
  logic [17:0] ram2 [0:1023];
  logic [17:0] ram1_q1, ram2_q1, ram2_q2;

  always @(posedge clk_50M) begin
    if (bus1.mem_wren) ram1[bus1.mem_address] <= bus1.mem_write;
    ram1_q1 <= ram1[bus1.mem_address];
  end

  always @(posedge clk_50M) begin
    if (bus2.mem_wren) ram2[bus2.mem_address] <= bus2.mem_write;
    ram2_q1 <= ram2[bus2.mem_address];
    ram2_q2 <= ram2_q1;
  end

  assign bus1.mem_read = ram1_q1;
  assign bus2.mem_read = ram2_q2;

  initial begin
    clk_50M = 1'b0;
    forever #5 clk_50M = ~clk_50M;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_50M);
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [9:0] addr, input logic [17:0] wd);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [9:0] addr, input logic [17:0] wd);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd;
  endtask

  initial begin
    reset_n = 1'b0;
    m0_exclusive = 1'b0;
    set_m0(1'b0, 1'b0, 10'h000, 18'h00000);
    set_m1(1'b0, 1'b0, 10'h000, 18'h00000);
    next_cycle();
    next_cycle();

    // Reset state
    sample();
    check_eq("rst_pulses", {bus1.m0_ack, bus1.m1_ack, bus1.m0_rvalid, bus1.m1_rvalid, bus1.mem_wren}, 32'd0);
    check_eq("rst_addr", bus1.mem_address, 32'h000);
    check_eq("rst_rdata", {bus1.m0_rdata, bus1.m1_rdata}, 32'd0);
    next_cycle();

    // m0 writes 0x2ABCD to 0x005, then reads it back in the next cycle
    reset_n = 1'b1;
    set_m0(1'b1, 1'b1, 10'h005, 18'h2ABCD);
    sample();
    check_eq("wr5_ack", bus1.m0_ack, 32'd1);
    check_eq("wr5_wren", bus1.mem_wren, 32'd1);
    check_eq("wr5_data", bus1.mem_write, 32'h2ABCD);
    next_cycle();
    set_m0(1'b1, 1'b0, 10'h005, 18'h00000);
    sample();
    check_eq("rd5_ack", bus1.m0_ack, 32'd1);
    check_eq("rd5_m1ack", bus1.m1_ack, 32'd0);
    check_eq("rd5_addr", bus1.mem_address, 32'h005);
    check_eq("rd5_wren", bus1.mem_wren, 32'd0);
    next_cycle();
    set_m0(1'b0, 1'b0, 10'h000, 18'h00000);
    sample();
    check_eq("rd5_rv_l1", bus1.m0_rvalid, 32'd1);
    check_eq("rd5_data_l1", bus1.m0_rdata, 32'h2ABCD);
    check_eq("rd5_m1rv_l1", bus1.m1_rvalid, 32'd0);
    check_eq("rd5_early_l2", bus2.m0_rvalid, 32'd0);
    next_cycle();
    sample();
    check_eq("rd5_rv_end_l1", bus1.m0_rvalid, 32'd0);
    check_eq("rd5_hold_l1", bus1.m0_rdata, 32'h2ABCD);
    check_eq("rd5_rv_l2", bus2.m0_rvalid, 32'd1);
    check_eq("rd5_data_l2", bus2.m0_rdata, 32'h2ABCD);
    check_eq("rd5_m1rv_l2", bus2.m1_rvalid, 32'd0);
    next_cycle();

    // Contention from reset: no grant in reset, then strict alternation
    reset_n = 1'b0;
    set_m0(1'b1, 1'b0, 10'h010, 18'h00000);
    set_m1(1'b1, 1'b0, 10'h020, 18'h00000);
    sample();
    check_eq("rst_nogrant", {bus1.m0_ack, bus1.m1_ack, bus2.m0_ack, bus2.m1_ack}, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      sample();
      check_eq("rr_ack0", bus1.m0_ack, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("rr_ack1", bus1.m1_ack, (i % 2 == 0) ? 32'd0 : 32'd1);
      check_eq("rr_ack0_l2", bus2.m0_ack, (i % 2 == 0) ? 32'd1 : 32'd0);
      cnt0 += int'(bus1.m0_ack);
      cnt1 += int'(bus1.m1_ack);
      next_cycle();
    end
    check_eq("rr_cnt0", cnt0, 32'd4);
    check_eq("rr_cnt1", cnt1, 32'd4);

    // m0 alone: wins and moves prio to m1
    set_m1(1'b0, 1'b0, 10'h020, 18'h00000);
    sample();
    check_eq("solo_m0", bus1.m0_ack, 32'd1);
    next_cycle();

    // Exclusive for 8 cycles: m0 always wins, prio untouched
    m0_exclusive = 1'b1;
    set_m1(1'b1, 1'b0, 10'h020, 18'h00000);
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      sample();
      cnt0 += int'(bus1.m0_ack);
      cnt1 += int'(bus1.m1_ack);
      next_cycle();
    end
    check_eq("ex_cnt0", cnt0, 32'd8);
    check_eq("ex_cnt1", cnt1, 32'd0);
    m0_exclusive = 1'b0;
    sample();
    check_eq("ex_after_m1", bus1.m1_ack, 32'd1);
    check_eq("ex_after_m0", bus1.m0_ack, 32'd0);
    next_cycle();

    // Drain outstanding reads, then 10 idle cycles
    set_m0(1'b0, 1'b0, 10'h000, 18'h00000);
    set_m1(1'b0, 1'b0, 10'h000, 18'h00000);
    next_cycle();
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      sample();
      check_eq("idle_pulses", {bus1.mem_wren, bus1.m0_ack, bus1.m1_ack, bus1.m0_rvalid, bus1.m1_rvalid,
                               bus2.mem_wren, bus2.m0_ack, bus2.m1_ack, bus2.m0_rvalid, bus2.m1_rvalid}, 32'd0);
      check_eq("idle_addr", bus1.mem_address, 32'h020);
      next_cycle();
    end

    // m1 writes 0x3FFFF to 0x3FF, then reads it in the next cycle
    set_m1(1'b1, 1'b1, 10'h3FF, 18'h3FFFF);
    sample();
    check_eq("wr3ff_ack", bus1.m1_ack, 32'd1);
    check_eq("wr3ff_wren", bus1.mem_wren, 32'd1);
    check_eq("wr3ff_addr", bus1.mem_address, 32'h3FF);
    check_eq("wr3ff_data", bus1.mem_write, 32'h3FFFF);
    next_cycle();
    set_m1(1'b1, 1'b0, 10'h3FF, 18'h00000);
    sample();
    check_eq("rd3ff_ack", bus1.m1_ack, 32'd1);
    check_eq("rd3ff_wren", bus1.mem_wren, 32'd0);
    check_eq("wr_no_rvalid", bus1.m1_rvalid, 32'd0);
    next_cycle();
    set_m1(1'b0, 1'b0, 10'h000, 18'h00000);
    sample();
    check_eq("rd3ff_rv_l1", bus1.m1_rvalid, 32'd1);
    check_eq("rd3ff_data_l1", bus1.m1_rdata, 32'h3FFFF);
    check_eq("rd3ff_wren_after", bus1.mem_wren, 32'd0);
    check_eq("wr_no_rvalid_l2", bus2.m1_rvalid, 32'd0);
    next_cycle();
    sample();
    check_eq("rd3ff_rv_l2", bus2.m1_rvalid, 32'd1);
    check_eq("rd3ff_data_l2", bus2.m1_rdata, 32'h3FFFF);
    check_eq("rd3ff_rv_end_l1", bus1.m1_rvalid, 32'd0);
    next_cycle();

    // Reset arrives on the edge after an m0 read is acked
    set_m0(1'b1, 1'b0, 10'h005, 18'h00000);
    sample();
    check_eq("rm_ack", bus1.m0_ack, 32'd1);
    next_cycle();
    reset_n = 1'b0;
    set_m0(1'b0, 1'b0, 10'h000, 18'h00000);
    sample();
    check_eq("rm_rv_in_rst", {bus1.m0_rvalid, bus2.m0_rvalid}, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    sample();
    check_eq("rm_outs_l1", {bus1.mem_address, bus1.mem_write, bus1.mem_wren, bus1.m0_ack, bus1.m1_ack}, 32'd0);
    check_eq("rm_rdata_l1", {bus1.m0_rdata, bus1.m1_rdata}, 32'd0);
    check_eq("rm_rdata_l2", {bus2.m0_rdata, bus2.m1_rdata}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) sample();
      check_eq("rm_no_rvalid", {bus1.m0_rvalid, bus1.m1_rvalid, bus2.m0_rvalid, bus2.m1_rvalid}, 32'd0);
      next_cycle();
    end

    // prio was cleared by reset: m0 wins the first contended grant
    set_m0(1'b1, 1'b0, 10'h001, 18'h00000);
    set_m1(1'b1, 1'b0, 10'h002, 18'h00000);
    sample();
    check_eq("rm_prio_m0", {bus1.m0_ack, bus1.m1_ack}, 32'd2);
    check_eq("rm_prio_m0_l2", {bus2.m0_ack, bus2.m1_ack}, 32'd2);
    next_cycle();
    set_m0(1'b0, 1'b0, 10'h000, 18'h00000);
    set_m1(1'b0, 1'b0, 10'h000, 18'h00000);
    next_cycle();
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
